// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle of the register-file scoreboard.
// The master side is the pipeline; the slave side is the scoreboard.
interface regfile_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_regwrite;
  logic        id_longlat;
  logic        id_flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] busy;
  logic [2:0]  pending_cnt;
  logic        err_underflow;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_regwrite, id_longlat, id_flush, wb_valid, wb_rd,
    input  stall, busy, pending_cnt, err_underflow
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_regwrite, id_longlat, id_flush, wb_valid, wb_rd,
    output stall, busy, pending_cnt, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for long-latency register writes with RAW/WAW/capacity stall.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback release dependents immediately.
module regfile_scoreboard #(
  parameter int MAX_PEND = 4
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave sb
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_PEND);

  logic [31:0] busy_r;
  logic [2:0]  cnt_r;
  logic        err_r;

  logic [31:0] eb_s;
  logic        clr_s;
  logic        underflow_s;
  logic        rd_nz_s;
  logic        raw_s;
  logic        waw_s;
  logic        full_s;
  logic        stall_s;
  logic        issue_s;
  logic [31:0] busy_nxt_s;
  logic [2:0]  cnt_nxt_s;
  logic        err_nxt_s;

  // One-hot mask of a register index; x0 never maps to a bit.
  function automatic logic [31:0] onehot_nz(input logic [4:0] idx);
    logic [31:0] m;
    m = 32'd0;
    if (idx != 5'd0) begin
      m[idx] = 1'b1;
    end else begin
      m = 32'd0;
    end
    return m;
  endfunction

  // Busy lookup with x0 always reading as free.
  function automatic logic bit_at(input logic [31:0] vec, input logic [4:0] idx);
    return (idx != 5'd0) & vec[idx];
  endfunction

  // Hazard detection and issue qualification for the instruction in decode.
  always_comb begin
    clr_s       = sb.wb_valid & bit_at(busy_r, sb.wb_rd);
    underflow_s = sb.wb_valid & (sb.wb_rd != 5'd0) & ~busy_r[sb.wb_rd];
`ifdef SCOREBOARD_BYPASS_EN
    eb_s = clr_s ? (busy_r & ~onehot_nz(sb.wb_rd)) : busy_r;
`else
    eb_s = busy_r;
`endif
    rd_nz_s = (sb.id_rd != 5'd0);
    raw_s   = (sb.id_uses_rs1 & bit_at(eb_s, sb.id_rs1)) |
              (sb.id_uses_rs2 & bit_at(eb_s, sb.id_rs2));
    waw_s   = sb.id_regwrite & rd_nz_s & eb_s[sb.id_rd];
    full_s  = sb.id_longlat & sb.id_regwrite & rd_nz_s & (cnt_r == MAX_CNT) & ~clr_s;
    stall_s = sb.id_valid & ~sb.id_flush & (raw_s | waw_s | full_s);
    issue_s = sb.id_valid & ~sb.id_flush & ~stall_s & sb.id_regwrite &
              sb.id_longlat & rd_nz_s;
  end

  // Next-state for busy bits, pending count and sticky error; a set beats a clear.
  always_comb begin
    busy_nxt_s = busy_r;
    cnt_nxt_s  = cnt_r;
    err_nxt_s  = err_r | underflow_s;
    if (clr_s) begin
      busy_nxt_s = busy_nxt_s & ~onehot_nz(sb.wb_rd);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (issue_s) begin
      busy_nxt_s = busy_nxt_s | onehot_nz(sb.id_rd);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
    case ({issue_s, clr_s})
      2'b10: begin
        if (cnt_r < MAX_CNT) begin
          cnt_nxt_s = cnt_r + 3'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01: begin
        if (cnt_r != 3'd0) begin
          cnt_nxt_s = cnt_r - 3'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Scoreboard state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 32'd0;
      cnt_r  <= 3'd0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  assign sb.stall         = stall_s;
  assign sb.busy          = busy_r;
  assign sb.pending_cnt   = cnt_r;
  assign sb.err_underflow = err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, corner sequences, then random
// traffic checked against a queue-of-pending-destinations reference model.
module tb_regfile_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXP = 4;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        rw;
    logic        ll;
    logic        fl;
    logic        wv;
    logic [4:0]  wrd;
    logic        e_stall;
    logic [31:0] e_busy;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_stall;
  int   pq[$];
  bit   m_err;
  vec_t tbl[19];

  regfile_scoreboard_if sbif ();

  regfile_scoreboard #(.MAX_PEND(MAXP)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sbif)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic rst, logic v, logic [4:0] rs1, logic [4:0] rd,
                              logic u1, logic rw, logic ll, logic fl, logic wv,
                              logic [4:0] wrd, logic es, logic [31:0] eb,
                              logic [2:0] ec, logic ee);
    vec_t t;
    t.rst = rst; t.v = v; t.rs1 = rs1; t.rs2 = 5'd0; t.rd = rd;
    t.u1 = u1; t.u2 = 1'b0; t.rw = rw; t.ll = ll; t.fl = fl;
    t.wv = wv; t.wrd = wrd;
    t.e_stall = es; t.e_busy = eb; t.e_cnt = ec; t.e_err = ee;
    return t;
  endfunction

  function automatic bit in_q(int r);
    if (r == 0) return 1'b0;
    foreach (pq[i]) if (pq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit vis(int r, bit clr, int wrd);
    return in_q(r) && !(BYP && clr && (r == wrd));
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = 32'd0;
    foreach (pq[i]) b[pq[i]] = 1'b1;
    return b;
  endfunction

  task automatic drive(input vec_t t);
    reset            = t.rst;
    sbif.id_valid    = t.v;
    sbif.id_rs1      = t.rs1;
    sbif.id_rs2      = t.rs2;
    sbif.id_rd       = t.rd;
    sbif.id_uses_rs1 = t.u1;
    sbif.id_uses_rs2 = t.u2;
    sbif.id_regwrite = t.rw;
    sbif.id_longlat  = t.ll;
    sbif.id_flush    = t.fl;
    sbif.wb_valid    = t.wv;
    sbif.wb_rd       = t.wrd;
  endtask

  // Check stall for the driven inputs, advance one edge, check registered state.
  task automatic run_cycle();
    bit clr, uf, st, iss;
    int wrd, rd;
    #1;
    wrd = int'(sbif.wb_rd);
    rd  = int'(sbif.id_rd);
    clr = sbif.wb_valid && in_q(wrd);
    uf  = sbif.wb_valid && (wrd != 0) && !in_q(wrd);
    st  = sbif.id_valid && !sbif.id_flush &&
          ((sbif.id_uses_rs1 && vis(int'(sbif.id_rs1), clr, wrd)) ||
           (sbif.id_uses_rs2 && vis(int'(sbif.id_rs2), clr, wrd)) ||
           (sbif.id_regwrite && vis(rd, clr, wrd)) ||
           (sbif.id_longlat && sbif.id_regwrite && rd != 0 && pq.size() == MAXP && !clr));
    iss = sbif.id_valid && !sbif.id_flush && !st && sbif.id_regwrite &&
          sbif.id_longlat && rd != 0;
    last_stall = sbif.stall;
    chk("model_stall", sbif.stall, st);
    @(posedge clk);
    if (reset) begin
      pq.delete();
      m_err = 1'b0;
    end else begin
      if (clr) begin
        for (int i = 0; i < pq.size(); i++) begin
          if (pq[i] == wrd) begin
            pq.delete(i);
            break;
          end
        end
      end
      if (iss) pq.push_back(rd);
      if (uf) m_err = 1'b1;
    end
    #1;
    chk("model_busy", sbif.busy, m_busy());
    chk("model_cnt", sbif.pending_cnt, pq.size());
    chk("model_err", sbif.err_underflow, m_err);
  endtask

  initial begin
    // rst v rs1 rd u1 rw ll fl wv wrd | stall busy cnt err
    tbl[0]  = mk(0, 1, 0, 5,  0, 1, 1, 0, 0, 0, 0, 32'h20,  3'd1, 0);
    tbl[1]  = mk(0, 1, 5, 6,  1, 1, 0, 0, 0, 0, 1, 32'h20,  3'd1, 0);
    tbl[2]  = mk(0, 1, 5, 6,  1, 1, 0, 0, 0, 0, 1, 32'h20,  3'd1, 0);
    tbl[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 5, 0, 32'h0,   3'd0, 0);
    tbl[4]  = mk(0, 1, 5, 6,  1, 1, 0, 0, 0, 0, 0, 32'h0,   3'd0, 0);
    tbl[5]  = mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 32'h0,   3'd0, 0);
    tbl[6]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 32'h0,   3'd0, 0);
    tbl[7]  = mk(0, 1, 0, 3,  0, 1, 1, 0, 0, 0, 0, 32'h8,   3'd1, 0);
    tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 0, 32'h8,   3'd1, 1);
    tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h8,   3'd1, 1);
    tbl[10] = mk(0, 1, 0, 7,  0, 1, 1, 1, 0, 0, 0, 32'h8,   3'd1, 1);
    tbl[11] = mk(0, 1, 3, 0,  1, 0, 0, 1, 0, 0, 0, 32'h8,   3'd1, 1);
    tbl[12] = mk(0, 1, 0, 10, 0, 1, 1, 0, 0, 0, 0, 32'h408, 3'd2, 1);
    tbl[13] = mk(0, 1, 0, 11, 0, 1, 1, 0, 0, 0, 0, 32'hC08, 3'd3, 1);
    tbl[14] = mk(0, 1, 0, 11, 0, 1, 0, 0, 0, 0, 1, 32'hC08, 3'd3, 1);
    tbl[15] = mk(1, 1, 0, 12, 0, 1, 1, 0, 0, 0, 0, 32'h0,   3'd0, 0);
    tbl[16] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 3, 0, 32'h0,   3'd0, 1);
    tbl[17] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0,   3'd0, 0);
    tbl[18] = mk(0, 1, 3, 0,  1, 0, 0, 0, 0, 0, 0, 32'h0,   3'd0, 0);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 3'd0, 0));
    repeat (2) @(posedge clk);
    #1;
    pq.delete();
    m_err = 1'b0;
    chk("reset_busy", sbif.busy, 32'h0);
    chk("reset_cnt", sbif.pending_cnt, 3'd0);
    chk("reset_err", sbif.err_underflow, 1'b0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      run_cycle();
      chk($sformatf("vec%0d_stall", i), last_stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_busy", i), sbif.busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_cnt", i), sbif.pending_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d_err", i), sbif.err_underflow, tbl[i].e_err);
    end

    // Fill to capacity, then a fifth load stalls until a writeback frees a slot.
    for (int r = 1; r <= 4; r++) begin
      drive(mk(0, 1, 0, 5'(r), 0, 1, 1, 0, 0, 0, 0, 32'h0, 3'd0, 0));
      run_cycle();
    end
    drive(mk(0, 1, 0, 6, 0, 1, 1, 0, 0, 0, 0, 32'h0, 3'd0, 0));
    run_cycle();
    chk("full_stall", last_stall, 1'b1);
    chk("full_cnt", sbif.pending_cnt, 3'd4);
    drive(mk(0, 1, 0, 6, 0, 1, 1, 0, 1, 1, 0, 32'h0, 3'd0, 0));
    run_cycle();
    chk("full_release_stall", last_stall, 1'b0);
    chk("full_release_cnt", sbif.pending_cnt, 3'd4);
    chk("full_release_busy", sbif.busy, 32'h5C);

    // Writeback of x2 while decode reads x2.
    drive(mk(0, 1, 2, 8, 1, 1, 0, 0, 1, 2, 0, 32'h0, 3'd0, 0));
    run_cycle();
    chk("bypass_same_cycle", last_stall, BYP ? 1'b0 : 1'b1);
    drive(mk(0, 1, 2, 8, 1, 1, 0, 0, 0, 0, 0, 32'h0, 3'd0, 0));
    run_cycle();
    chk("bypass_next_cycle", last_stall, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 99) == 0);
      sbif.id_valid    = ($urandom_range(0, 3) != 0);
      sbif.id_rs1      = 5'($urandom_range(0, 7));
      sbif.id_rs2      = 5'($urandom_range(0, 7));
      sbif.id_rd       = 5'($urandom_range(0, 7));
      sbif.id_uses_rs1 = 1'($urandom_range(0, 1));
      sbif.id_uses_rs2 = 1'($urandom_range(0, 1));
      sbif.id_regwrite = ($urandom_range(0, 3) != 0);
      sbif.id_longlat  = 1'($urandom_range(0, 1));
      sbif.id_flush    = ($urandom_range(0, 7) == 0);
      sbif.wb_valid    = ($urandom_range(0, 2) == 0);
      if (pq.size() != 0 && $urandom_range(0, 3) != 0) begin
        sbif.wb_rd = 5'(pq[$urandom_range(0, pq.size() - 1)]);
      end else begin
        sbif.wb_rd = 5'($urandom_range(0, 7));
      end
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PEND, default 4, meaning max outstanding long-latency writes (legal range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  valid instruction present in decode.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  decode source/dest register indices.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  source actually read.
REQ-007 SHALL have port id_regwrite  input  1  decode instruction writes id_rd.
REQ-008 SHALL have port id_longlat  input  1  result returns later via wb port (load/multicycle).
REQ-009 SHALL have port id_flush  input  1  decode instruction killed this cycle.
REQ-010 SHALL have ports wb_valid  input  1, wb_rd  input  5  long-latency writeback completing this cycle.
REQ-011 SHALL have port stall  output  1  hold fetch/decode this cycle.
REQ-012 SHALL have port busy  output  32  registered pending-write bit per register.
REQ-013 SHALL have port pending_cnt  output  3  number of set busy bits.
REQ-014 SHALL have port err_underflow  output  1  sticky protocol-error flag.

Function
REQ-015 Register 0 SHALL never become busy; wb_rd==0 SHALL be ignored entirely.
REQ-016 clr SHALL be wb_valid & wb_rd!=0 & busy[wb_rd]; on clr, busy[wb_rd] SHALL clear at next edge.
REQ-017 Effective busy view eb SHALL equal busy (macro off) or busy with bit wb_rd masked when clr (macro on).
REQ-018 stall SHALL be combinational: id_valid & ~id_flush & (RAW | WAW | FULL).
REQ-019 RAW SHALL be (id_uses_rs1 & eb[id_rs1]) | (id_uses_rs2 & eb[id_rs2]), x0 excluded.
REQ-020 WAW SHALL be id_regwrite & id_rd!=0 & eb[id_rd].
REQ-021 FULL SHALL be id_longlat & id_regwrite & id_rd!=0 & (pending_cnt==MAX_PEND) & ~clr.
REQ-022 issue SHALL be id_valid & ~id_flush & ~stall & id_regwrite & id_longlat & id_rd!=0; on issue busy[id_rd] SHALL set at next edge.
REQ-023 Same-cycle clr and issue on same index SHALL leave bit set (set wins).
REQ-024 pending_cnt SHALL update next edge: +1 issue only, -1 clr only, unchanged both/neither; never exceeds MAX_PEND nor wraps below 0.
REQ-025 wb_valid with wb_rd!=0 and busy[wb_rd]==0 SHALL set err_underflow at next edge, cause no other state change.
REQ-026 err_underflow SHALL stay 1 until reset.
REQ-027 id_flush SHALL suppress issue and stall that cycle but SHALL NOT alter existing busy bits or count.
REQ-028 Stall latency SHALL be 0 cycles; a cleared bit SHALL unblock decode no later than cycle after clr.

Reset
REQ-029 On reset high at an edge: busy=0, pending_cnt=0, err_underflow=0, overriding same-cycle issue/clr.
REQ-030 While reset high, stall SHALL still follow REQ-018 using cleared registered state after first edge; outstanding writebacks arriving after reset SHALL set err_underflow.

Configuration
REQ-031 Macro SCOREBOARD_BYPASS_EN SHALL select REQ-017 masking: defined -> same-cycle writeback releases dependents in that cycle (regfile write-first required); undefined -> dependents stall one extra cycle.
REQ-032 All other behaviour SHALL be identical with and without SCOREBOARD_BYPASS_EN.

Verification
REQ-033 Load x5 issued (id_longlat=1,rd=5), next cycle id_rs1=5 used -> stall=1, busy[5]=1, pending_cnt=1 until wb_rd=5.
REQ-034 wb_valid wb_rd=5 while decode reads x5 -> stall=0 that cycle with macro, stall=1 that cycle and 0 next without.
REQ-035 Issue 4 loads to x1..x4 (MAX_PEND=4), fifth load to x6 -> stall=1; wb_rd=1 same cycle -> stall=0, cnt stays 4, busy[6]=1.
REQ-036 Load with rd=0, then wb_valid wb_rd=0 -> busy=0, cnt=0, err_underflow=0, stall=0.
REQ-037 wb_valid wb_rd=9 with busy[9]=0 -> err_underflow=1 next cycle and sticks; busy, cnt unchanged.
REQ-038 Load to x7 with id_flush=1 -> busy[7]=0; reset asserted with cnt=3 -> busy=0, cnt=0 next cycle.
